pattern_ram_loader: RTL and testbench
=====================================

# pattern_ram_loader

Block RAM and load controller sitting directly upstream of the pattern generator. Owns the 2^RAM_ADDR_BITS × 8 pattern RAM. Fills it from the UART receive byte stream in address-incrementing bursts, and optionally reads bursts back to the UART transmitter. While the pattern generator reports `pattern_active`, the RAM read port is handed to the generator and all loader access is locked out.

## Interface
- `RAM_ADDR_BITS`, default 8: RAM address width; depth is 2^RAM_ADDR_BITS bytes.
- `clk` input 1: single clock; every register is in this domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `pattern_active` input 1: from the pattern generator; high grants it the RAM read port.
- `ram_addr_pat_gen` input RAM_ADDR_BITS: generator read address.
- `ram_data` output 8: registered RAM read data; feeds both the generator and the readback path.
- `cfg_start_address` input RAM_ADDR_BITS: first address of a burst.
- `cfg_burst_length` input RAM_ADDR_BITS: burst byte count minus 1.
- `cfg_write_start` input 1: level; its rising edge starts a write burst.
- `cfg_read_start` input 1: level; its rising edge starts a readback burst.
- `rx_byte` input 8: UART receive data.
- `rx_valid` input 1: one-cycle strobe qualifying `rx_byte`.
- `tx_byte` output 8: readback byte to the UART transmitter.
- `tx_valid` output 1: one-cycle strobe qualifying `tx_byte`.
- `tx_busy` input 1: UART transmitter busy.
- `loader_busy` output 1: high in any state other than IDLE.
- `loader_error` output 1: sticky flag; set when a burst is rejected or aborted.

## Operation
- Start detection:
  - Both start inputs are rising-edge detected through one delay flop each; the delay flops reset to 0.
  - Edges are acted on only in IDLE. An edge that arrives in any other state is discarded.
- Read-port address mux: `pattern_active` high selects `ram_addr_pat_gen`; otherwise the loader's current address is selected. The RAM has a single write port, driven only by the loader.
- FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT.
- From IDLE:
  - Write edge with `pattern_active` low: load the address from `cfg_start_address`, clear the count, go to WRITE, clear `loader_error`.
  - Read edge with `pattern_active` low: same initialisation, go to RD_ADDR.
  - Both edges in the same cycle: the write burst wins and the read edge is dropped.
  - Any start edge with `pattern_active` high: set `loader_error` and stay in IDLE.
- WRITE state:
  - Each `rx_valid` writes `rx_byte` to the current address.
  - If count == `cfg_burst_length`, go to IDLE; otherwise increment the address and the count.
  - `rx_valid` outside WRITE is ignored.
- RD_ADDR state: the current address is presented to the RAM; go to RD_WAIT next cycle.
- RD_WAIT state:
  - Wait while `tx_busy` is high.
  - When `tx_busy` is low: drive `tx_byte` = `ram_data`, pulse `tx_valid` for one cycle.
  - Then go to IDLE if count == `cfg_burst_length`; otherwise increment the address and count and go to RD_ADDR.
- Abort: `pattern_active` rising while in WRITE, RD_ADDR or RD_WAIT:
  - Go to IDLE the next cycle and set `loader_error`.
  - No write or `tx_valid` occurs in that cycle or after it.
- Address arithmetic:
  - The address increments modulo 2^RAM_ADDR_BITS, so a burst wraps from all-ones to 0.
  - The count is RAM_ADDR_BITS wide, giving bursts of 1 to 2^RAM_ADDR_BITS bytes.
- Config inputs are sampled once at burst start (address) or compared live (length). `cfg_burst_length` must be held stable for the whole burst.

## Timing
- Reset values: `ram_data` 8'h00, `tx_byte` 8'h00, `tx_valid` 0, `loader_busy` 0, `loader_error` 0, FSM state IDLE. RAM contents are not reset.
- Start latency: the input rises in cycle N; the edge is detected and the FSM leaves IDLE at cycle N+1; `loader_busy` is high from N+1.
- Write: the byte is in the RAM on the clock edge that samples `rx_valid`. Back-to-back `rx_valid` on consecutive cycles is supported.
- Read: `ram_data` is valid one cycle after the address is applied.
  - Generator path: 1-cycle latency from `ram_addr_pat_gen`.
  - Readback: at least 2 cycles per byte.
- The transmitter must raise `tx_busy` within 1 cycle of `tx_valid`. This is covered by the RD_ADDR cycle after each strobe.

## Configuration
- `PATTERN_RAM_READBACK_EN` defined: RD_ADDR and RD_WAIT are built and readback operates as described above.
- `PATTERN_RAM_READBACK_EN` undefined:
  - `cfg_read_start` is ignored and sets no error.
  - `tx_valid` is tied to 0 and `tx_byte` to 8'h00.
  - The FSM contains only IDLE and WRITE.

## Test plan
- Write 4 bytes: start 8'h10, length 3, rx 8'hA5, 8'h5A, 8'h01, 8'hFF → RAM[0x10..0x13] holds those values, `loader_busy` falls after the 4th strobe, `loader_error` 0.
- Wrap: start 8'hFE, length 3, rx 1, 2, 3, 4 → RAM[FE]=1, RAM[FF]=2, RAM[00]=3, RAM[01]=4.
- Readback (macro defined): read start 8'h10, length 3, `tx_busy` held high for 5 cycles after each strobe → exactly 4 `tx_valid` pulses carrying A5, 5A, 01, FF, each issued only with `tx_busy` low.
- Lockout: `pattern_active` high, then `cfg_write_start` rises → no RAM write, `loader_error` 1. A `ram_addr_pat_gen` of 8'h11 returns 8'h5A one cycle later.
- Abort: `pattern_active` rises after the 2nd byte of a 4-byte write → only 2 bytes are written, FSM reaches IDLE next cycle, `loader_error` 1. The next accepted start clears `loader_error`.
- Reset mid-burst: `rst_n` low during WRITE → all outputs take their reset values immediately; following `rx_valid` strobes cause no writes.

Source files
------------

// File: rtl/pattern_ram_loader.sv
// Pattern RAM with a UART-fed burst loader and optional burst readback (PATTERN_RAM_READBACK_EN).
// The generator owns the read port whenever pattern_active is high; loader activity is then locked out.
module pattern_ram_loader #(
  parameter int RAM_ADDR_BITS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pattern_active,
  input  logic [RAM_ADDR_BITS-1:0] ram_addr_pat_gen,
  output logic [7:0]               ram_data,
  input  logic [RAM_ADDR_BITS-1:0] cfg_start_address,
  input  logic [RAM_ADDR_BITS-1:0] cfg_burst_length,
  input  logic                     cfg_write_start,
  input  logic                     cfg_read_start,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_valid,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_busy,
  output logic                     loader_busy,
  output logic                     loader_error
);

  localparam int DEPTH = 1 << RAM_ADDR_BITS;

`ifdef PATTERN_RAM_READBACK_EN
  typedef enum logic [1:0] {IDLE, WRITE, RD_ADDR, RD_WAIT} state_e;
`else
  typedef enum logic {IDLE, WRITE} state_e;
`endif

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_ADDR_BITS-1:0] count_q, count_d;
  logic                     error_q, error_d;
  logic                     wr_start_q;
  logic                     wr_edge, rd_edge, last_beat;
  logic                     ram_we;
  logic [RAM_ADDR_BITS-1:0] rd_addr;
  logic [7:0]               ram_data_q;
  logic [7:0]               mem [DEPTH];

  assign wr_edge   = cfg_write_start & ~wr_start_q;
  assign last_beat = (count_q == cfg_burst_length);

`ifdef PATTERN_RAM_READBACK_EN
  logic rd_start_q;
  assign rd_edge = cfg_read_start & ~rd_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_start_q <= 1'b0;
    else        rd_start_q <= cfg_read_start;
  end
`else
  assign rd_edge = 1'b0;
  logic unused_readback;
  assign unused_readback = &{1'b0, cfg_read_start, tx_busy};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
      wr_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      error_q    <= error_d;
      wr_start_q <= cfg_write_start;
    end
  end

  // A non-IDLE state can only see pattern_active high if it rose during the burst, so a level test is the abort.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    error_d = error_q;
    case (state_q)
      IDLE: begin
        if (wr_edge || rd_edge) begin
          if (pattern_active) begin
            error_d = 1'b1;
          end else begin
            addr_d  = cfg_start_address;
            count_d = '0;
            error_d = 1'b0;
`ifdef PATTERN_RAM_READBACK_EN
            state_d = wr_edge ? WRITE : RD_ADDR;
`else
            state_d = WRITE;
`endif
          end
        end
      end
      WRITE: begin
        if (pattern_active) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (rx_valid) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + RAM_ADDR_BITS'(1);
            count_d = count_q + RAM_ADDR_BITS'(1);
          end
        end
      end
`ifdef PATTERN_RAM_READBACK_EN
      RD_ADDR: begin
        if (pattern_active) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (pattern_active) begin
          state_d = IDLE;
          error_d = 1'b1;
        end else if (!tx_busy) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + RAM_ADDR_BITS'(1);
            count_d = count_q + RAM_ADDR_BITS'(1);
            state_d = RD_ADDR;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_we      = (state_q == WRITE) && rx_valid && !pattern_active;
    rd_addr     = pattern_active ? ram_addr_pat_gen : addr_q;
    loader_busy = (state_q != IDLE);
`ifdef PATTERN_RAM_READBACK_EN
    tx_valid    = (state_q == RD_WAIT) && !tx_busy && !pattern_active;
`else
    tx_valid    = 1'b0;
`endif
    tx_byte     = tx_valid ? ram_data_q : 8'h00;
  end

  assign loader_error = error_q;
  assign ram_data     = ram_data_q;

  always_ff @(posedge clk) begin
    if (ram_we) mem[addr_q] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ram_data_q <= 8'h00;
    else        ram_data_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_pattern_ram_loader.sv
// Directed bench for pattern_ram_loader: burst writes, wrap, readback, lockout, abort and reset mid-burst.
module tb_pattern_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pattern_active;
  logic [7:0] ram_addr_pat_gen;
  logic [7:0] ram_data;
  logic [7:0] cfg_start_address;
  logic [7:0] cfg_burst_length;
  logic       cfg_write_start;
  logic       cfg_read_start;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_busy;
  logic       loader_busy;
  logic       loader_error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pattern_ram_loader #(.RAM_ADDR_BITS(8)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pattern_active    (pattern_active),
    .ram_addr_pat_gen  (ram_addr_pat_gen),
    .ram_data          (ram_data),
    .cfg_start_address (cfg_start_address),
    .cfg_burst_length  (cfg_burst_length),
    .cfg_write_start   (cfg_write_start),
    .cfg_read_start    (cfg_read_start),
    .rx_byte           (rx_byte),
    .rx_valid          (rx_valid),
    .tx_byte           (tx_byte),
    .tx_valid          (tx_valid),
    .tx_busy           (tx_busy),
    .loader_busy       (loader_busy),
    .loader_error      (loader_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_write(input logic [7:0] a, input logic [7:0] l);
    cfg_start_address = a;
    cfg_burst_length  = l;
    cfg_write_start   = 1'b1;
    tick();
    cfg_write_start   = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    pattern_active   = 1'b1;
    ram_addr_pat_gen = a;
    tick();
    d = ram_data;
    pattern_active = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] w4  [4];
    logic [7:0] ab  [4];
    logic [7:0] rs  [4];
    logic [7:0] rb_exp [4];
    w4 = '{8'hA5, 8'h5A, 8'h01, 8'hFF};
    ab = '{8'h11, 8'h22, 8'hC2, 8'hC3};
    rs = '{8'hD1, 8'hE1, 8'hE2, 8'hE3};
    rb_exp = '{8'hA5, 8'h5A, 8'h01, 8'hFF};

    rst_n = 1'b0;
    pattern_active = 1'b0; ram_addr_pat_gen = 8'h00;
    cfg_start_address = 8'h00; cfg_burst_length = 8'h00;
    cfg_write_start = 1'b0; cfg_read_start = 1'b0;
    rx_byte = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0;
    #12;
    check("rst_ram_data", ram_data, 8'h00);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_busy", loader_busy, 0);
    check("rst_error", loader_error, 0);
    rst_n = 1'b1;
    tick();

    // Four-byte write at 0x10
    start_write(8'h10, 8'd3);
    check("w4_busy_start", loader_busy, 1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("w4_busy_before_last", loader_busy, 1);
      send(w4[i]);
    end
    check("w4_busy_end", loader_busy, 0);
    check("w4_error", loader_error, 0);
    for (int i = 0; i < 4; i++) begin
      peek(8'h10 + 8'(i), d);
      check($sformatf("w4_ram[%0h]", 8'h10 + 8'(i)), d, w4[i]);
    end

    // Wrap from 0xFE through 0x01
    start_write(8'hFE, 8'd3);
    for (int i = 0; i < 4; i++) send(8'(i + 1));
    check("wrap_busy_end", loader_busy, 0);
    for (int i = 0; i < 4; i++) begin
      peek(8'hFE + 8'(i), d);
      check($sformatf("wrap_ram[%0h]", 8'hFE + 8'(i)), d, 8'(i + 1));
    end

`ifdef PATTERN_RAM_READBACK_EN
    begin
      int pulses = 0;
      int busy_cnt = 0;
      cfg_start_address = 8'h10;
      cfg_burst_length  = 8'd3;
      cfg_read_start    = 1'b1;
      tick();
      cfg_read_start    = 1'b0;
      check("rb_busy_start", loader_busy, 1);
      for (int c = 0; c < 60; c++) begin
        @(posedge clk);
        #1;
        tx_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
        @(negedge clk);
        if (tx_valid) begin
          check("rb_busy_at_strobe", tx_busy, 0);
          if (pulses < 4) check($sformatf("rb_byte%0d", pulses), tx_byte, rb_exp[pulses]);
          pulses++;
          busy_cnt = 5;
        end
      end
      tx_busy = 1'b0;
      check("rb_pulse_count", pulses, 4);
      check("rb_busy_end", loader_busy, 0);
      check("rb_error", loader_error, 0);
    end
`else
    begin
      int seen = 0;
      cfg_start_address = 8'h10;
      cfg_burst_length  = 8'd3;
      cfg_read_start    = 1'b1;
      tick();
      cfg_read_start    = 1'b0;
      check("rd_ignored_busy", loader_busy, 0);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (tx_valid) seen++;
      end
      check("rd_ignored_tx", seen, 0);
      check("rd_ignored_error", loader_error, 0);
    end
`endif

    // Lockout: start while the generator owns the RAM
    pattern_active    = 1'b1;
    cfg_start_address = 8'h11;
    cfg_burst_length  = 8'd0;
    cfg_write_start   = 1'b1;
    rx_byte = 8'h77; rx_valid = 1'b1;
    tick();
    cfg_write_start = 1'b0;
    rx_valid = 1'b0;
    check("lock_busy", loader_busy, 0);
    check("lock_error", loader_error, 1);
    ram_addr_pat_gen = 8'h11;
    tick();
    check("lock_pat_gen_read", ram_data, 8'h5A);
    pattern_active = 1'b0;

    // Preload 0x20..0x23, then abort a second burst after two bytes
    start_write(8'h20, 8'd3);
    check("start_clears_error", loader_error, 0);
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i));
    start_write(8'h20, 8'd3);
    send(8'h11);
    send(8'h22);
    pattern_active = 1'b1;
    rx_byte = 8'h33; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check("abort_idle", loader_busy, 0);
    check("abort_error", loader_error, 1);
    send(8'h44);
    pattern_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      peek(8'h20 + 8'(i), d);
      check($sformatf("abort_ram[%0h]", 8'h20 + 8'(i)), d, ab[i]);
    end
    start_write(8'h40, 8'd0);
    check("abort_next_clears", loader_error, 0);
    send(8'h99);
    check("single_byte_done", loader_busy, 0);

    // Reset in the middle of a burst
    start_write(8'h50, 8'd3);
    for (int i = 0; i < 4; i++) send(8'hE0 + 8'(i));
    start_write(8'h50, 8'd3);
    send(8'hD1);
    check("rstmid_busy_before", loader_busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", loader_busy, 0);
    check("rstmid_ram_data", ram_data, 8'h00);
    check("rstmid_tx_valid", tx_valid, 0);
    check("rstmid_tx_byte", tx_byte, 8'h00);
    check("rstmid_error", loader_error, 0);
    send(8'hBB);
    send(8'hBB);
    rst_n = 1'b1;
    send(8'hCC);
    send(8'hCC);
    check("rstmid_idle_after", loader_busy, 0);
    for (int i = 0; i < 4; i++) begin
      peek(8'h50 + 8'(i), d);
      check($sformatf("rstmid_ram[%0h]", 8'h50 + 8'(i)), d, rs[i]);
    end
    peek(8'h00, d);
    check("rstmid_ram[0]", d, 8'h03);
    peek(8'h01, d);
    check("rstmid_ram[1]", d, 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
